// File: rtl/regfile_pkg.sv
// Shared writeback types for the register file and its writeback arbiter.
package regfile_pkg;

    localparam int REG_NUM_W = 5;
    localparam int DATA_W    = 32;
    // Queue occupancy width; covers 0..4 for the supported DEPTH range.
    localparam int CNT_W     = 3;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef struct packed {
        logic [REG_NUM_W-1:0] num;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    // A pending write to r0 never blocks a reader, and reading r0 is never busy.
    function automatic logic reg_hit(input logic [REG_NUM_W-1:0] pending_num,
                                     input logic [REG_NUM_W-1:0] read_num);
        return (read_num != '0) && (pending_num == read_num);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry writeback request FIFO with occupancy count and a
// two-port register-number match over the currently valid entries.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  wb_req_t              push_req,
    input  logic                 pop,
    output wb_req_t              head,
    output logic [CNT_W-1:0]     count,
    input  logic [REG_NUM_W-1:0] match1_num,
    input  logic [REG_NUM_W-1:0] match2_num,
    output logic                 match1,
    output logic                 match2
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t            mem_q [DEPTH];
    wb_req_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   off;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and count.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Match only entries that sit between the read pointer and read pointer + count.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(off) < count_q) begin
                if (reg_hit(mem_q[i].num, match1_num)) match1 = 1'b1;
                if (reg_hit(mem_q[i].num, match2_num)) match2 = 1'b1;
            end
        end
    end

    // Control state; synchronous reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter: two per-source FIFOs (ALU, load/mult-div) feed a single
// regfile write port under round-robin arbitration, plus scoreboard busy bits.
module regfile_wb_arb
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [REG_NUM_W-1:0] a_num,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [REG_NUM_W-1:0] b_num,
    input  logic [DATA_W-1:0]    b_data,
    output logic [REG_NUM_W-1:0] write_num,
    output logic [DATA_W-1:0]    write_data,
    output logic                 write_en,
    input  logic [REG_NUM_W-1:0] read1_num,
    input  logic [REG_NUM_W-1:0] read2_num,
    output logic                 busy1,
    output logic                 busy2
);

    wb_req_t              a_head, b_head;
    logic [CNT_W-1:0]     a_count, b_count;
    logic                 a_push, b_push;
    logic                 a_pop, b_pop;
    logic                 a_m1, a_m2, b_m1, b_m2;
    logic                 a_ne, b_ne;

    logic                 last_grant_q, last_grant_d;
    logic                 write_en_q, write_en_d;
    logic [REG_NUM_W-1:0] write_num_q, write_num_d;
    logic [DATA_W-1:0]    write_data_q, write_data_d;

    // Ready depends only on occupancy, never on a same-edge pop.
    assign a_ready = (a_count < CNT_W'(DEPTH));
    assign b_ready = (b_count < CNT_W'(DEPTH));
    assign a_push  = a_valid & a_ready;
    assign b_push  = b_valid & b_ready;
    assign a_ne    = (a_count != '0);
    assign b_ne    = (b_count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (a_push),
        .push_req   ('{num: a_num, data: a_data}),
        .pop        (a_pop),
        .head       (a_head),
        .count      (a_count),
        .match1_num (read1_num),
        .match2_num (read2_num),
        .match1     (a_m1),
        .match2     (a_m2)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (b_push),
        .push_req   ('{num: b_num, data: b_data}),
        .pop        (b_pop),
        .head       (b_head),
        .count      (b_count),
        .match1_num (read1_num),
        .match2_num (read2_num),
        .match1     (b_m1),
        .match2     (b_m2)
    );

    // Round-robin grant: on a tie the source not granted last wins; pops see pre-edge contents.
    always_comb begin
        a_pop        = a_ne & (~b_ne | (last_grant_q == SRC_B));
        b_pop        = b_ne & ~a_pop;
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        write_num_d  = write_num_q;
        write_data_d = write_data_q;
        if (a_pop) begin
            last_grant_d = SRC_A;
            write_num_d  = a_head.num;
            write_data_d = a_head.data;
            write_en_d   = (a_head.num != '0);
        end else if (b_pop) begin
            last_grant_d = SRC_B;
            write_num_d  = b_head.num;
            write_data_d = b_head.data;
            write_en_d   = (b_head.num != '0);
        end
    end

    // Output register and fairness state; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SRC_B;
            write_en_q   <= 1'b0;
            write_num_q  <= '0;
            write_data_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            write_num_q  <= write_num_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_num  = write_num_q;
    assign write_data = write_data_q;

    // A read is busy while its register is queued in either source or being written this cycle.
    assign busy1 = a_m1 | b_m1 | (write_en_q & reg_hit(write_num_q, read1_num));
    assign busy2 = a_m2 | b_m2 | (write_en_q & reg_hit(write_num_q, read2_num));

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter: DEPTH, 2, entries per source queue (power of two, 2..4).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a_valid  input  1  source A (ALU writeback) request valid.
REQ-005 a_ready  output  1  source A queue can accept.
REQ-006 a_num  input  5  source A destination register.
REQ-007 a_data  input  32  source A write data.
REQ-008 b_valid / b_ready / b_num / b_data  in/out/in/in  1/1/5/32  source B (load, mult/div) request; same meaning as source A.
REQ-009 write_num  output  5  regfile write register number.
REQ-010 write_data  output  32  regfile write data.
REQ-011 write_en  output  1  regfile write enable.
REQ-012 read1_num / read2_num  input  5  register numbers the issue stage is about to read.
REQ-013 busy1 / busy2  output  1  a write to read1_num / read2_num is still pending.

Function
REQ-014 A request SHALL be accepted at a posedge where valid and ready are both 1; x_ready SHALL be 1 exactly when that source's queue holds fewer than DEPTH entries, independent of valid and of same-cycle pops.
REQ-015 Each source queue SHALL be FIFO; per-source write order SHALL be preserved; no ordering across sources is guaranteed.
REQ-016 At each posedge, if at least one queue is non-empty, exactly one head entry SHALL be popped and registered onto write_num/write_data with write_en = 1 (write_en = 0 if num is 0); otherwise write_en SHALL become 0 and write_num/write_data hold.
REQ-017 Arbitration SHALL be round-robin: with both queues non-empty, grant the source not granted last; with one non-empty, grant it without updating fairness order beyond recording the grant.
REQ-018 last_grant SHALL reset to B, so A wins the first tie.
REQ-019 Latency: a request accepted at edge N into an empty queue with no contention SHALL drive write_en during cycle N+1 (regfile commits at edge N+2).
REQ-020 Push into an empty queue and pop in the same edge SHALL NOT occur (pop sees pre-edge contents); push and pop on a non-empty, non-full queue at one edge SHALL leave count unchanged.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-022 busyK SHALL be 1 (combinational) when readK_num != 0 and matches num of any valid queue entry in either queue or of the output register while write_en = 1; otherwise 0.
REQ-023 Writes to register 0 SHALL be accepted and popped normally but never assert write_en nor set busy.

Reset
REQ-024 At a posedge with rst_n = 0: both queues empty, last_grant = B, write_en = 0, write_num = 0, write_data = 0; a_ready = b_ready = 1 from the following cycle.
REQ-025 Reset mid-operation SHALL discard all queued and in-flight writes; no write_en pulse after the reset edge.
REQ-026 Requests presented while rst_n = 0 SHALL NOT be accepted.

Structure
REQ-027 Package regfile_pkg SHALL hold REG_NUM_W = 5, DATA_W = 32 and typedef wb_req_t {num, data}; shared with the regfile.
REQ-028 Sub-module wb_fifo (DEPTH-entry wb_req_t FIFO with count, push, pop, entry-valid match port) SHALL be instantiated once per source.

Verification
REQ-029 A only: reg 3 = 0x11111111 at edge 1 -> write_en, write_num 3, write_data 0x11111111 in cycle 2; busy1 = 1 for read1_num 3 in cycles 1-2.
REQ-030 Simultaneous A(5, 0xAAAA0000) and B(6, 0xBBBB0000) from reset -> A written cycle N+1, B cycle N+2; repeat tie -> B first.
REQ-031 Hold a_valid with 4 back-to-back A requests, B idle, DEPTH 2 -> a_ready low when 2 queued; all 4 written in order, no loss or duplicate.
REQ-032 A writes reg 0 with 0xDEADBEEF -> accepted, write_en stays 0, busy1 = 0 for read1_num 0.
REQ-033 Both queues full, rst_n low one edge -> write_en 0 next cycle, no further writes, readies 1, busy 0.
REQ-034 Random A/B traffic 1000 cycles vs. scoreboard model -> per-source order preserved, no starvation beyond 1 grant, busy matches model every cycle.
